seq_bin_to_bcd: RTL and testbench

Multi-cycle, parametrised binary-to-BCD converter using double-dabble, with one shift-and-adjust step per clock.
- Serves the score/level/lines readouts feeding the seven-segment and VGA digit renderers.
- Replaces wide unrolled combinational conversion, so there is no long adder chain for large widths.
- Adds a valid/ready handshake, saturating overflow detection and an optional leading-zero mask.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/seq_bin_to_bcd.sv | 145 ++++++++++++++
 tb/tb_seq_bin_to_bcd.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;
    localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - combinational double-dabble nibble correction (add 3 when >= 5)
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// rtl/seq_bin_to_bcd.sv - one-step-per-clock double-dabble converter with saturation
// Optional leading-zero display mask enabled by defining BCD_LZ_BLANK_EN.
module seq_bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int BINARY_WIDTH = 16,
    parameter int BCD_DIGITS   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BINARY_WIDTH-1:0] in_binary,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_bcd [BCD_DIGITS-1:0],
    output logic                    out_overflow
`ifdef BCD_LZ_BLANK_EN
    ,
    output logic [BCD_DIGITS-1:0]   out_digit_en
`endif
);

    localparam int BCD_W = BCD_DIGITS * 4;
    localparam int SR_W  = BCD_W + BINARY_WIDTH;
    localparam int CNT_W = $clog2(BINARY_WIDTH + 1);

    b2b_state_t        state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              capture;

    bcd_digit_t        out_bcd_q [BCD_DIGITS-1:0];
    logic              out_ovf_q;

    logic [BCD_W-1:0]  bcd_adj;
    logic [SR_W-1:0]   sr_shift;
    logic              carry_out;
    logic              last_step;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (sr_q[BINARY_WIDTH + 4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    // The bit leaving the top nibble is the only way a value can exceed the digit capacity.
    assign carry_out = bcd_adj[BCD_W-1];
    assign sr_shift  = {bcd_adj[BCD_W-2:0], sr_q[BINARY_WIDTH-1:0], 1'b0};
    assign last_step = (cnt_q == CNT_W'(BINARY_WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = {{BCD_W{1'b0}}, in_binary};
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + CNT_W'(1);
                ovf_d = ovf_q | carry_out;
                if (last_step) begin
                    state_d = DONE;
                    capture = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result registers load only on the final shift, so partial values never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < BCD_DIGITS; j++) begin
                out_bcd_q[j] <= '0;
            end
            out_ovf_q <= 1'b0;
        end else if (capture) begin
            for (int j = 0; j < BCD_DIGITS; j++) begin
                out_bcd_q[j] <= ovf_d ? BCD_MAX_DIGIT : sr_shift[BINARY_WIDTH + 4*j +: 4];
            end
            out_ovf_q <= ovf_d;
        end
    end

`ifdef BCD_LZ_BLANK_EN
    logic [BCD_DIGITS-1:0] digit_en_d, digit_en_q;
    logic                  lz_seen;

    always_comb begin
        lz_seen    = 1'b0;
        digit_en_d = '0;
        for (int j = BCD_DIGITS - 1; j >= 0; j--) begin
            lz_seen       = lz_seen | (sr_shift[BINARY_WIDTH + 4*j +: 4] != 4'd0);
            digit_en_d[j] = lz_seen | (j == 0) | ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_en_q <= '1;
        end else if (capture) begin
            digit_en_q <= digit_en_d;
        end
    end

    assign out_digit_en = digit_en_q;
`endif

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_bcd      = out_bcd_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// tb/tb_seq_bin_to_bcd.sv - randomized and directed self-checking bench for seq_bin_to_bcd
module tb_seq_bin_to_bcd;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_binary = '0;

    logic        rdy5, val5, ovf5;
    logic [3:0]  bcd5 [4:0];
    logic        rdy4, val4, ovf4;
    logic [3:0]  bcd4 [3:0];
`ifdef BCD_LZ_BLANK_EN
    logic [4:0]  en5;
    logic [3:0]  en4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_bin_to_bcd #(.BINARY_WIDTH(16), .BCD_DIGITS(5)) u_dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (rdy5),
        .in_binary    (in_binary),
        .out_valid    (val5),
        .out_ready    (out_ready),
        .out_bcd      (bcd5),
        .out_overflow (ovf5)
`ifdef BCD_LZ_BLANK_EN
        ,
        .out_digit_en (en5)
`endif
    );

    seq_bin_to_bcd #(.BINARY_WIDTH(16), .BCD_DIGITS(4)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (rdy4),
        .in_binary    (in_binary),
        .out_valid    (val4),
        .out_ready    (out_ready),
        .out_bcd      (bcd4),
        .out_overflow (ovf4)
`ifdef BCD_LZ_BLANK_EN
        ,
        .out_digit_en (en4)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned p10(input int n);
        int unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int exp_digit(input int unsigned v, input int j, input int nd);
        if (v >= p10(nd)) return 9;
        return int'((v / p10(j)) % 10);
    endfunction

    function automatic logic [31:0] exp_en(input bit have, input int unsigned v, input int nd);
        logic [31:0] e = '0;
        for (int j = 0; j < nd; j++)
            e[j] = !have || (v >= p10(nd)) || (j == 0) || ((v / p10(j)) != 0);
        return e;
    endfunction

    // Behavioural model: 0 = waiting for input, 1 = converting, 2 = result offered
    int          m_state = 0;
    int          m_left  = 0;
    int unsigned m_pend  = 0;
    int unsigned m_val   = 0;
    bit          m_have  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_val   = 0;
            m_have  = 1'b0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_state = 1;
                    m_left  = W;
                    m_pend  = in_binary;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_state = 2;
                        m_val   = m_pend;
                        m_have  = 1'b1;
                    end
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready5", rdy5, m_state == 0);
        chk("out_valid5", val5, m_state == 2);
        chk("in_ready4", rdy4, m_state == 0);
        chk("out_valid4", val4, m_state == 2);
        chk("ovf5", ovf5, m_val >= 100000);
        chk("ovf4", ovf4, m_val >= 10000);
        for (int j = 0; j < 5; j++) chk($sformatf("bcd5[%0d]", j), bcd5[j], exp_digit(m_val, j, 5));
        for (int j = 0; j < 4; j++) chk($sformatf("bcd4[%0d]", j), bcd4[j], exp_digit(m_val, j, 4));
`ifdef BCD_LZ_BLANK_EN
        chk("en5", en5, exp_en(m_have, m_val, 5));
        chk("en4", en4, exp_en(m_have, m_val, 4));
`endif
    end

    task automatic start(input int unsigned v);
        int n = 0;
        int lat = 0;
        @(posedge clk); #2;
        while (!rdy5 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("ready_wait", rdy5, 1);
        in_valid  = 1'b1;
        in_binary = v[15:0];
        @(posedge clk); #2;
        in_valid = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!val5 && lat < 100);
        chk("latency", lat, W);
    endtask

    task automatic release_out(input int stall);
        repeat (stall) @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset_ready", rdy5, 1);
        chk("reset_valid", val5, 0);
        chk("reset_bcd0", bcd5[0], 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        start(0);
        for (int j = 0; j < 5; j++) chk("lit_zero", bcd5[j], 0);
        chk("lit_zero_ovf", ovf5, 0);
`ifdef BCD_LZ_BLANK_EN
        chk("lit_en_zero", en5, 5'b00001);
`endif
        release_out(0);

        start(65535);
        chk("lit_ffff_d4", bcd5[4], 6);
        chk("lit_ffff_d3", bcd5[3], 5);
        chk("lit_ffff_d2", bcd5[2], 5);
        chk("lit_ffff_d1", bcd5[1], 3);
        chk("lit_ffff_d0", bcd5[0], 5);
        chk("lit_ffff_ovf4", ovf4, 1);
        release_out(1);

        start(12345);
        chk("lit_12345_ovf4", ovf4, 1);
        for (int j = 0; j < 4; j++) chk("lit_12345_sat", bcd4[j], 9);
        chk("lit_12345_d5_0", bcd5[0], 5);
        release_out(0);

        start(9999);
        chk("lit_9999_ovf4", ovf4, 0);
        for (int j = 0; j < 4; j++) chk("lit_9999", bcd4[j], 9);
        release_out(0);

        start(4321);
        release_out(10);

        start(10000);
        chk("lit_10000_d4", bcd5[4], 1);
`ifdef BCD_LZ_BLANK_EN
        chk("lit_en_10000", en5, 5'b11111);
`endif
        release_out(0);

        // Abort mid-conversion at shift count 7
        @(posedge clk); #2;
        in_valid  = 1'b1;
        in_binary = 16'd1234;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_ready", rdy5, 1);
        chk("abort_valid", val5, 0);
        chk("abort_bcd3", bcd5[3], 0);
        chk("abort_ovf4", ovf4, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        start(42);
        chk("lit_42_d4", bcd5[4], 0);
        chk("lit_42_d3", bcd5[3], 0);
        chk("lit_42_d2", bcd5[2], 0);
        chk("lit_42_d1", bcd5[1], 4);
        chk("lit_42_d0", bcd5[0], 2);
`ifdef BCD_LZ_BLANK_EN
        chk("lit_en_42", en5, 5'b00011);
`endif
        release_out(0);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #2;
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: in_binary = 16'd0;
                1: in_binary = 16'hFFFF;
                2: in_binary = 16'($urandom_range(9990, 10010));
                3: in_binary = 16'($urandom_range(0, 99));
                4: in_binary = 16'($urandom_range(990, 1010));
                default: in_binary = 16'($urandom);
            endcase
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
